// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: pops a push/pop FIFO and packs RATIO words into one valid/ready beat.
// Optional partial-pack idle flush is enabled with FIFO_DRAIN_PACKER_TIMEOUT_EN.
module fifo_drain_packer #(
    parameter int MSBD    = 3,
    parameter int RATIO   = 4,
    parameter int MSBC    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MSBD:0]               fifoDataOut,
    input  logic                        fifoEmpty,
    input  logic                        fifoFull,
    input  logic                        fifoPush,
    output logic                        pop,
    output logic [RATIO*(MSBD+1)-1:0]   outData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [MSBC:0]               outCount
);
    localparam int W  = MSBD + 1;
    localparam int BW = RATIO * W;
    localparam logic [MSBC:0] LAST_IDX = (MSBC+1)'(RATIO - 1);
    localparam logic [MSBC:0] FULL_CNT = (MSBC+1)'(RATIO);

    if (RATIO < 2 || (1 << (MSBC + 1)) <= RATIO || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_drain_packer: invalid parameter combination");
    end

    typedef enum logic {FILL, STALL} state_t;

    state_t          state_q, state_d;
    logic [MSBC:0]   idx_q, idx_d;
    logic [BW-1:0]   pack_q, pack_d, pack_w;
    logic [BW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [MSBC:0]   out_count_q, out_count_d;
    logic            fill, taken, out_free, last, load, flush;

    assign fill     = (state_q == FILL);
    // a pop presented together with an accepted push is ignored by the FIFO
    assign taken    = pop & ~(fifoPush & ~fifoFull);
    assign out_free = ~out_valid_q | outReady;
    assign last     = taken & (idx_q == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= FILL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = fill ? ((last & ~out_free) ? STALL : FILL) : (out_free ? FILL : STALL);
    end

    always_comb begin
        pop = reset_n & ~fifoEmpty & fill;
    end

`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          idling;

    // flush fires on the cycle the idle count reaches TIMEOUT, or later if the output is busy
    always_comb begin
        idling = fill & ~taken & (idx_q != '0);
        flush  = idling & (idle_q >= IW'(TIMEOUT - 1)) & out_free;
        idle_d = (taken | flush) ? '0 :
                 (idling & (idle_q != IW'(TIMEOUT))) ? idle_q + 1'b1 : idle_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        pack_w = pack_q;
        if (taken) pack_w[int'(idx_q)*W +: W] = fifoDataOut;
    end

    always_comb begin
        load        = (fill ? last & out_free : out_free) | flush;
        idx_d       = load ? '0 : (taken ? idx_q + 1'b1 : idx_q);
        pack_d      = load ? '0 : pack_w;
        out_data_d  = load ? pack_w : out_data_q;
        out_count_d = load ? (flush ? idx_q : FULL_CNT) : out_count_q;
        out_valid_d = load | (out_valid_q & ~outReady);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign outCount = out_count_q;
endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb_fifo_drain_packer: directed plus randomized checks of fifo_drain_packer against a queue-based model.
module tb_fifo_drain_packer;
    localparam int W  = 4;
    localparam int R  = 4;
    localparam int BW = R * W;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  fifoDataOut = '0;
    logic          fifoEmpty = 1'b0;
    logic          fifoFull = 1'b0;
    logic          fifoPush = 1'b0;
    logic          pop;
    logic [BW-1:0] outData;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [2:0]    outCount;

    int pass_n = 0;
    int total_n = 0;

    typedef struct {
        logic [BW-1:0] d;
        int            n;
    } beat_t;

    beat_t        done[$];
    logic [W-1:0] cur[$];

    fifo_drain_packer #(.MSBD(W-1), .RATIO(R), .MSBC(2), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .fifoDataOut(fifoDataOut), .fifoEmpty(fifoEmpty),
        .fifoFull(fifoFull), .fifoPush(fifoPush), .pop(pop), .outData(outData),
        .outValid(outValid), .outReady(outReady), .outCount(outCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic beat_t mk();
        beat_t b;
        b.d = '0;
        foreach (cur[i]) b.d[i*W +: W] = cur[i];
        b.n = cur.size();
        return b;
    endfunction

    // Model: completed beats wait in order; the FIFO is drained only while fewer than two are pending.
    always @(negedge clock) begin : cmp
        logic m_pop, m_taken, fill;
`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
        logic free;
        int   m_idle;
`endif
        if (!reset_n) begin
            chk("rst_pop", pop, 0);
            chk("rst_valid", outValid, 0);
            chk("rst_data", outData, 0);
            chk("rst_count", outCount, 0);
            done.delete();
            cur.delete();
`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
            m_idle = 0;
`endif
        end else begin
            fill  = done.size() < 2;
            m_pop = !fifoEmpty && fill;
            chk("pop", pop, m_pop);
            chk("valid", outValid, done.size() > 0);
            if (done.size() > 0) begin
                chk("data", outData, done[0].d);
                chk("count", outCount, done[0].n);
            end
`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
            free = done.size() == 0 || outReady;
`endif
            m_taken = m_pop && !(fifoPush && !fifoFull);
            if (done.size() > 0 && outReady) void'(done.pop_front());
            if (m_taken) begin
                cur.push_back(fifoDataOut);
                if (cur.size() == R) begin
                    done.push_back(mk());
                    cur.delete();
                end
            end
`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
            if (m_taken) m_idle = 0;
            else if (fill && cur.size() > 0) begin
                if (m_idle + 1 >= TO && free) begin
                    done.push_back(mk());
                    cur.delete();
                    m_idle = 0;
                end else if (m_idle < TO) m_idle++;
            end
`endif
        end
    end

    task automatic step(input logic e, input logic [W-1:0] d, input logic p, input logic f, input logic r);
        fifoEmpty = e;
        fifoDataOut = d;
        fifoPush = p;
        fifoFull = f;
        outReady = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pes[4] = '{0, 30, 70, 95};
        int prs[4] = '{100, 60, 20, 90};
        int pe, pr, n;
        repeat (3) @(posedge clock);
        #1;
        chk("hold_rst_pop", pop, 0);
        reset_n = 1'b1;
        #1;
        chk("release_pop", pop, 1);

        step(0, 4'h1, 0, 0, 1);
        step(0, 4'h2, 0, 0, 1);
        step(0, 4'h3, 0, 0, 1);
        chk("basic_not_yet", outValid, 0);
        step(0, 4'h4, 0, 0, 1);
        chk("basic_valid", outValid, 1);
        chk("basic_data", outData, 16'h4321);
        chk("basic_count", outCount, 4);

        step(1, 4'h0, 0, 0, 1);
        step(0, 4'h1, 0, 0, 1);
        step(0, 4'h2, 0, 0, 1);
        step(0, 4'h3, 1, 0, 1);
        step(0, 4'h3, 0, 0, 1);
        chk("coll_not_yet", outValid, 0);
        step(0, 4'h4, 0, 0, 1);
        chk("coll_data", outData, 16'h4321);

        step(1, 4'h0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 4'(5 + i), 0, 0, 0);
        fifoEmpty = 1'b0;
        #1;
        chk("stall_pop", pop, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        chk("bp_hold_data", outData, 16'h8765);
        chk("bp_hold_valid", outValid, 1);
        step(1, 4'h0, 0, 0, 1);
        chk("bp_beat2_valid", outValid, 1);
        chk("bp_beat2_data", outData, 16'hCBA9);
        step(1, 4'h0, 0, 0, 1);
        chk("bp_drained", outValid, 0);

        step(0, 4'hD, 0, 0, 1);
        step(1, 4'h7, 0, 0, 1);
        step(0, 4'hE, 0, 0, 1);
        step(1, 4'h7, 0, 0, 1);
        step(0, 4'hF, 0, 0, 1);
        step(1, 4'h7, 0, 0, 1);
        step(0, 4'h1, 0, 0, 1);
        chk("gap_data", outData, 16'h1FED);
        chk("gap_count", outCount, 4);
        step(1, 4'h0, 0, 0, 1);

`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
        step(0, 4'hA, 0, 0, 1);
        step(0, 4'hB, 0, 0, 1);
        n = 0;
        fifoEmpty = 1'b1;
        while (!outValid && n < 20) begin
            step(1, 4'h0, 0, 0, 1);
            n++;
        end
        chk("to_wait", n, TO);
        chk("to_data", outData, 16'h00BA);
        chk("to_count", outCount, 2);
        step(1, 4'h0, 0, 0, 1);
`endif

        step(0, 4'h1, 0, 0, 0);
        step(0, 4'h2, 0, 0, 0);
        reset_n = 1'b0;
        fifoEmpty = 1'b0;
        #1;
        chk("midrst_pop", pop, 0);
        chk("midrst_valid", outValid, 0);
        step(0, 4'h0, 0, 0, 1);
        reset_n = 1'b1;

        for (int k = 0; k < 4000; k++) begin
            pe = pes[(k / 500) % 4];
            pr = prs[(k / 700) % 4];
            reset_n = ($urandom_range(0, 999) != 0);
            fifoEmpty = ($urandom_range(0, 99) < pe);
            fifoDataOut = W'($urandom);
            fifoPush = ($urandom_range(0, 99) < 30);
            fifoFull = ($urandom_range(0, 99) < 30);
            outReady = ($urandom_range(0, 99) < pr);
            @(posedge clock);
            #1;
        end

        reset_n = 1'b1;
        step(1, 4'h0, 0, 0, 1);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
